// File: rtl/alram_pkg.sv
// Shared definitions for the polynomial-buffer RAM arbiter family.
// State encoding and requester-id width reused by wider variants.
package alram_pkg;

   typedef enum logic {
      CLR = 1'b0,
      RUN = 1'b1
   } state_t;

   localparam int IDW = 1;

endpackage

// File: rtl/alram_arb_rr_arb2.sv
// Two-input round-robin arbiter; the pointer names the requester that
// wins the next conflict and only moves when both inputs request.
module rr_arb2
   import alram_pkg::*;
(
   input  logic       i_clk,
   input  logic       i_rst,
   input  logic       i_en,
   input  logic [1:0] i_req,
   output logic [1:0] o_gnt
);

   logic r_ptr;

   always_comb begin
      o_gnt = 2'b00;
      if (i_en) begin
         unique case (i_req)
            2'b01:   o_gnt = 2'b01;
            2'b10:   o_gnt = 2'b10;
            2'b11:   o_gnt = r_ptr ? 2'b10 : 2'b01;
            default: o_gnt = 2'b00;
         endcase
      end
   end

   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         r_ptr <= 1'b0;
      end else if (i_en && (i_req == 2'b11)) begin
         r_ptr <= ~r_ptr;
      end
   end

endmodule

// File: rtl/alram_arb.sv
// Arbiter/sequencer for the shared 256b x 32 polynomial buffer RAM:
// clears the RAM, then round-robins each port between two requesters.
module alram_arb
   import alram_pkg::*;
#(
   parameter int WID  = 256,
   parameter int AWID = 5,
   parameter int DEP  = 1 << AWID
) (
   input  logic              i_clk,
   input  logic              i_rst,
   input  logic              i_init,
   output logic              o_busy,
   input  logic [1:0]        i_wr_vld,
   output logic [1:0]        o_wr_rdy,
   input  logic [2*AWID-1:0] i_wr_addr,
   input  logic [2*WID-1:0]  i_wr_data,
   input  logic [1:0]        i_rd_vld,
   output logic [1:0]        o_rd_rdy,
   input  logic [2*AWID-1:0] i_rd_addr,
   output logic [1:0]        o_rd_dval,
   output logic [WID-1:0]    o_rd_data,
   output logic              o_ram_we,
   output logic [AWID-1:0]   o_ram_wa,
   output logic [WID-1:0]    o_ram_wdi,
   output logic [AWID-1:0]   o_ram_ra,
   input  logic [WID-1:0]    i_ram_rdo
);

   state_t              r_state;
   state_t              w_nstate;
   logic [AWID-1:0]     r_clr_cnt;
   logic [AWID-1:0]     w_clr_nxt;
   logic                w_run;
   logic [1:0]          w_wgnt;
   logic [1:0]          w_rgnt;
   logic                w_rhit;
   logic [AWID-1:0]     w_ra_sel;
   logic [AWID-1:0]     r_ra;
   logic [1:0]          r_v;
   logic [IDW-1:0]      r_id0;
   logic [IDW-1:0]      r_id1;

   assign w_run = (r_state == RUN) && !i_rst;

   always_comb begin
      w_nstate  = r_state;
      w_clr_nxt = r_clr_cnt;
      unique case (r_state)
         CLR: begin
            w_clr_nxt = r_clr_cnt + 1'b1;
            if (r_clr_cnt == AWID'(DEP - 1)) begin
               w_nstate  = RUN;
               w_clr_nxt = '0;
            end
         end
         RUN: begin
            if (i_init) begin
               w_nstate  = CLR;
               w_clr_nxt = '0;
            end
         end
         default: w_nstate = CLR;
      endcase
   end

   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         r_state   <= CLR;
         r_clr_cnt <= '0;
      end else begin
         r_state   <= w_nstate;
         r_clr_cnt <= w_clr_nxt;
      end
   end

   rr_arb2 u_warb (
      .i_clk (i_clk),
      .i_rst (i_rst),
      .i_en  (w_run),
      .i_req (i_wr_vld),
      .o_gnt (w_wgnt)
   );

   rr_arb2 u_rarb (
      .i_clk (i_clk),
      .i_rst (i_rst),
      .i_en  (w_run),
      .i_req (i_rd_vld),
      .o_gnt (w_rgnt)
   );

   assign o_wr_rdy = w_wgnt;
   assign o_rd_rdy = w_rgnt;
   assign o_busy   = i_rst || (r_state == CLR);

   always_comb begin
      o_ram_we  = 1'b0;
      o_ram_wa  = '0;
      o_ram_wdi = '0;
      if (!i_rst) begin
         if (r_state == CLR) begin
            o_ram_we = 1'b1;
            o_ram_wa = r_clr_cnt;
         end else if (w_wgnt[1]) begin
            o_ram_we  = 1'b1;
            o_ram_wa  = i_wr_addr[AWID +: AWID];
            o_ram_wdi = i_wr_data[WID +: WID];
         end else if (w_wgnt[0]) begin
            o_ram_we  = 1'b1;
            o_ram_wa  = i_wr_addr[0 +: AWID];
            o_ram_wdi = i_wr_data[0 +: WID];
         end
      end
   end

   // Idle read cycles replay the last address; that RAM output is ignored.
   assign w_rhit   = |w_rgnt;
   assign w_ra_sel = w_rgnt[1] ? i_rd_addr[AWID +: AWID]
                               : i_rd_addr[0 +: AWID];
   assign o_ram_ra = i_rst ? '0 : (w_rhit ? w_ra_sel : r_ra);

   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         r_ra  <= '0;
         r_v   <= 2'b00;
         r_id0 <= '0;
         r_id1 <= '0;
      end else begin
         if (w_rhit) begin
            r_ra <= w_ra_sel;
         end
         r_v   <= {r_v[0], w_rhit};
         r_id0 <= w_rgnt[1];
         r_id1 <= r_id0;
      end
   end

   assign o_rd_dval = (r_v[1] && !i_rst) ? (r_id1[0] ? 2'b10 : 2'b01)
                                         : 2'b00;
   assign o_rd_data = i_ram_rdo;

endmodule

// File: tb/tb_alram_arb.sv
// Bench for alram_arb: RAM model, table vectors, directed corner
// sequences and held random traffic against a reference model.
module tb_alram_arb;

   localparam int WID  = 256;
   localparam int AWID = 5;
   localparam int DEP  = 32;

   logic              clk;
   logic              rst;
   logic              init;
   logic              busy;
   logic [1:0]        wr_vld;
   logic [1:0]        wr_rdy;
   logic [2*AWID-1:0] wr_addr;
   logic [2*WID-1:0]  wr_data;
   logic [1:0]        rd_vld;
   logic [1:0]        rd_rdy;
   logic [2*AWID-1:0] rd_addr;
   logic [1:0]        rd_dval;
   logic [WID-1:0]    rd_data;
   logic              ram_we;
   logic [AWID-1:0]   ram_wa;
   logic [WID-1:0]    ram_wdi;
   logic [AWID-1:0]   ram_ra;
   logic [WID-1:0]    ram_rdo;

   alram_arb #(.WID(WID), .AWID(AWID)) dut (
      .i_clk     (clk),
      .i_rst     (rst),
      .i_init    (init),
      .o_busy    (busy),
      .i_wr_vld  (wr_vld),
      .o_wr_rdy  (wr_rdy),
      .i_wr_addr (wr_addr),
      .i_wr_data (wr_data),
      .i_rd_vld  (rd_vld),
      .o_rd_rdy  (rd_rdy),
      .i_rd_addr (rd_addr),
      .o_rd_dval (rd_dval),
      .o_rd_data (rd_data),
      .o_ram_we  (ram_we),
      .o_ram_wa  (ram_wa),
      .o_ram_wdi (ram_wdi),
      .o_ram_ra  (ram_ra),
      .i_ram_rdo (ram_rdo)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // RAM: registered read address, registered data out
   logic [WID-1:0]  mem [DEP];
   logic [AWID-1:0] ra_q;
   initial begin
      for (int i = 0; i < DEP; i++) mem[i] = {8{32'hDEAD0000 | i}};
      ra_q    = '0;
      ram_rdo = '0;
   end
   always @(posedge clk) begin
      if (ram_we) mem[ram_wa] <= ram_wdi;
      ra_q    <= ram_ra;
      ram_rdo <= mem[ra_q];
   end

   int n_chk  = 0;
   int n_pass = 0;

   task automatic chk(string nm, logic [WID-1:0] act, logic [WID-1:0] exp);
      n_chk++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %h want %h", nm, act, exp);
   endtask

   // Reference model
   typedef struct {
      int             due;
      logic           id;
      logic [WID-1:0] d;
   } ret_t;

   logic [WID-1:0] mm [DEP];
   ret_t           q[$];
   int             clr_left;
   bit             wt;
   bit             rt;
   int             cyc;
   logic [1:0]     last_gw;
   logic [1:0]     last_gr;
   logic [1:0]     last_dval;
   logic [WID-1:0] last_rdata;
   logic           last_busy;

   function automatic logic [1:0] pick(logic [1:0] v, bit turn);
      if (v == 2'b11) return turn ? 2'b10 : 2'b01;
      return v;
   endfunction

   task automatic step(input logic [1:0] wv, input int wa0, input int wa1,
                       input logic [WID-1:0] wd0, input logic [WID-1:0] wd1,
                       input logic [1:0] rv, input int ra0, input int ra1,
                       input logic ini);
      logic [1:0]     ew;
      logic [1:0]     er;
      logic [1:0]     ed;
      logic [WID-1:0] edat;
      int             a;
      wr_vld  = wv;
      wr_addr = {AWID'(wa1), AWID'(wa0)};
      wr_data = {wd1, wd0};
      rd_vld  = rv;
      rd_addr = {AWID'(ra1), AWID'(ra0)};
      init    = ini;
      @(negedge clk);
      last_gw    = wr_rdy;
      last_gr    = rd_rdy;
      last_dval  = rd_dval;
      last_rdata = rd_data;
      last_busy  = busy;
      ew = 2'b00;
      er = 2'b00;
      if (clr_left > 0) begin
         chk("clr_busy", busy, 1);
         chk("clr_wrdy", wr_rdy, 0);
         chk("clr_rrdy", rd_rdy, 0);
         chk("clr_we", ram_we, 1);
         chk("clr_wa", ram_wa, DEP - clr_left);
         chk("clr_wdi", ram_wdi, 0);
      end else begin
         ew = pick(wv, wt);
         er = pick(rv, rt);
         chk("run_busy", busy, 0);
         chk("wr_rdy", wr_rdy, ew);
         chk("rd_rdy", rd_rdy, er);
         chk("ram_we", ram_we, |ew);
         if (ew != 2'b00) begin
            chk("ram_wa", ram_wa, ew[1] ? wa1 : wa0);
            chk("ram_wdi", ram_wdi, ew[1] ? wd1 : wd0);
         end
         if (er != 2'b00) chk("ram_ra", ram_ra, er[1] ? ra1 : ra0);
      end
      ed   = 2'b00;
      edat = '0;
      if (q.size() > 0 && q[0].due == cyc) begin
         ed   = q[0].id ? 2'b10 : 2'b01;
         edat = q[0].d;
         void'(q.pop_front());
      end
      chk("rd_dval", rd_dval, ed);
      if (ed != 2'b00) chk("rd_data", rd_data, edat);
      if (clr_left > 0) begin
         mm[DEP - clr_left] = '0;
         clr_left--;
      end else begin
         if (ew != 2'b00) begin
            a = ew[1] ? wa1 : wa0;
            mm[a % DEP] = ew[1] ? wd1 : wd0;
         end
         if (wv == 2'b11) wt = !wt;
         if (rv == 2'b11) rt = !rt;
         if (er != 2'b00) begin
            a = er[1] ? ra1 : ra0;
            q.push_back('{cyc + 2, er[1], mm[a % DEP]});
         end
         if (ini) clr_left = DEP;
      end
      cyc++;
      @(posedge clk);
      #1;
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) step(0, 0, 0, '0, '0, 0, 0, 0, 0);
   endtask

   task automatic reset_cycles(input int n);
      rst    = 1'b1;
      init   = 1'b0;
      wr_vld = 2'b00;
      rd_vld = 2'b00;
      for (int i = 0; i < n; i++) begin
         @(negedge clk);
         chk("rst_busy", busy, 1);
         chk("rst_wrdy", wr_rdy, 0);
         chk("rst_rrdy", rd_rdy, 0);
         chk("rst_we", ram_we, 0);
         chk("rst_dval", rd_dval, 0);
         chk("rst_wa", ram_wa, 0);
         chk("rst_ra", ram_ra, 0);
         chk("rst_rdata", rd_data, ram_rdo);
         @(posedge clk);
         #1;
      end
      rst      = 1'b0;
      clr_left = DEP;
      wt       = 0;
      rt       = 0;
      q.delete();
   endtask

   function automatic logic [WID-1:0] rnd_word();
      logic [WID-1:0] w;
      for (int i = 0; i < WID / 32; i++) w[i*32 +: 32] = $urandom;
      return w;
   endfunction

   typedef struct {
      logic [1:0] wv;
      logic [1:0] rv;
      logic [1:0] ew;
      logic [1:0] er;
   } vec_t;

   initial begin
      #1_000_000;
      $display("FAIL watchdog: got timeout want finish");
      $fatal(1, "watchdog");
   end

   initial begin
      vec_t           tbl [12];
      logic [1:0]     pw;
      logic [1:0]     pr;
      int             pwa [2];
      int             pra [2];
      logic [WID-1:0] pwd [2];
      logic           ini;
      int             nb;

      for (int i = 0; i < DEP; i++) mm[i] = {8{32'hDEAD0000 | i}};
      cyc = 0; clr_left = DEP; wt = 0; rt = 0;
      rst = 1'b1; init = 1'b0;
      wr_vld = '0; wr_addr = '0; wr_data = '0;
      rd_vld = '0; rd_addr = '0;

      @(posedge clk);
      #1;
      reset_cycles(3);
      idle(DEP);

      step(0, 0, 0, '0, '0, 2'b01, 7, 0, 0);
      idle(2);
      chk("rd7_dval", last_dval, 2'b01);
      chk("rd7_data", last_rdata, 0);

      tbl = '{
         '{2'b11, 2'b00, 2'b01, 2'b00},
         '{2'b11, 2'b00, 2'b10, 2'b00},
         '{2'b11, 2'b00, 2'b01, 2'b00},
         '{2'b11, 2'b00, 2'b10, 2'b00},
         '{2'b10, 2'b00, 2'b10, 2'b00},
         '{2'b11, 2'b00, 2'b01, 2'b00},
         '{2'b00, 2'b11, 2'b00, 2'b01},
         '{2'b00, 2'b11, 2'b00, 2'b10},
         '{2'b00, 2'b11, 2'b00, 2'b01},
         '{2'b00, 2'b11, 2'b00, 2'b10},
         '{2'b01, 2'b01, 2'b01, 2'b01},
         '{2'b11, 2'b11, 2'b10, 2'b01}
      };
      for (int i = 0; i < 12; i++) begin
         step(tbl[i].wv, 3, 4, {8{32'h0300_0000 + i}}, {8{32'h0400_0000 + i}},
              tbl[i].rv, 3, 4, 0);
         chk("tbl_wrdy", last_gw, tbl[i].ew);
         chk("tbl_rrdy", last_gr, tbl[i].er);
      end
      idle(2);

      step(2'b01, 9, 0, {32{8'hA5}}, '0, 2'b10, 0, 9, 0);
      idle(2);
      chk("haz_dval", last_dval, 2'b10);
      chk("haz_data", last_rdata, {32{8'hA5}});

      for (int i = 0; i < DEP; i++) step(2'b01, i, 0, WID'(i), '0, 0, 0, 0, 0);
      for (int i = 0; i < DEP; i++) step(0, 0, 0, '0, '0, 2'b10, 0, i, 0);
      idle(2);

      step(0, 0, 0, '0, '0, 2'b01, 5, 0, 0);
      step(0, 0, 0, '0, '0, 2'b10, 0, 6, 1);
      nb = 0;
      for (int i = 0; i < DEP; i++) begin
         step(2'b11, 1, 2, '1, '1, 2'b11, 1, 2, 0);
         if (last_busy) nb++;
      end
      chk("reinit_busy_len", nb, DEP);
      for (int i = 0; i < DEP; i++) step(0, 0, 0, '0, '0, 2'b01, i, 0, 0);
      idle(2);

      pw = 0; pr = 0;
      pwa = '{0, 0}; pra = '{0, 0};
      pwd = '{'0, '0};
      for (int c = 0; c < 400; c++) begin
         for (int k = 0; k < 2; k++) begin
            if (!pw[k]) begin
               pw[k]  = 1'($urandom_range(0, 1));
               pwa[k] = int'($urandom_range(0, DEP - 1));
               pwd[k] = rnd_word();
            end
            if (!pr[k]) begin
               pr[k]  = 1'($urandom_range(0, 1));
               pra[k] = int'($urandom_range(0, DEP - 1));
            end
         end
         ini = ($urandom_range(0, 79) == 0);
         step(pw, pwa[0], pwa[1], pwd[0], pwd[1], pr, pra[0], pra[1], ini);
         pw = pw & ~last_gw;
         pr = pr & ~last_gr;
      end
      idle(DEP + 2);

      step(0, 0, 0, '0, '0, 2'b10, 0, 1, 0);
      step(0, 0, 0, '0, '0, 2'b01, 2, 0, 0);
      reset_cycles(2);
      idle(10);
      reset_cycles(2);
      nb = 0;
      for (int i = 0; i < DEP + 2; i++) begin
         idle(1);
         if (last_busy) nb++;
      end
      chk("midclr_busy_len", nb, DEP);

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
